// File: rtl/ntt_pkg.sv
// Shared types and latency derivation for the NTT controller.
package ntt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWait,
    StDone
  } ntt_state_e;

  // Operand memory returns read data one cycle after the address.
  localparam int unsigned MemRdLat = 1;

  // Read-to-write-back distance: memory read plus butterfly pipeline.
  function automatic int unsigned wb_lat(input int unsigned bf_lat);
    return bf_lat + MemRdLat;
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly operand and twiddle address generator.
// For stage s (m = 2^s) and butterfly index j: a = (j/m)*2m + j%m, b = a + m,
// tw = (j%m) << (LOGN-1-s).
module ntt_addr_gen #(
  parameter int LOGN = 8,
  parameter int SW   = $clog2(LOGN)
) (
  input  logic [LOGN-2:0] j,
  input  logic [SW-1:0]   s,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [LOGN-2:0] tw
);

  logic [LOGN-1:0] m;
  logic [LOGN-1:0] blk;
  logic [LOGN-2:0] k_mask;
  logic [LOGN-2:0] k;

  // Split j into block base and in-block offset, then spread blocks by 2m.
  always_comb begin
    m      = LOGN'(1) << s;
    k_mask = ~({(LOGN-1){1'b1}} << s);
    k      = j & k_mask;
    blk    = ({1'b0, j} >> s) << s;
    addr_a = (blk << 1) | {1'b0, k};
    addr_b = addr_a | m;
    tw     = k << (SW'(LOGN - 1) - s);
  end

endmodule

// File: rtl/ntt_ctrl.sv
// NTT/INTT in-place transform sequencer: issues one butterfly per cycle per
// stage, waits for the write-back pipeline to drain between stages, and
// replays read addresses as write-back addresses after the pipeline delay.
// Optional macro NTT_CTRL_STALL_EN adds a stall input that freezes sequencing.
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int LOGN   = 8,
  parameter int BF_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    inverse,
`ifdef NTT_CTRL_STALL_EN
  input  logic                    stall,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    mode,
  output logic                    rd_en,
  output logic [LOGN-1:0]         rd_addr_a,
  output logic [LOGN-1:0]         rd_addr_b,
  output logic [LOGN-2:0]         tw_addr,
  output logic                    wr_en,
  output logic [LOGN-1:0]         wr_addr_a,
  output logic [LOGN-1:0]         wr_addr_b,
  output logic [$clog2(LOGN)-1:0] stage
);

  localparam int SW = $clog2(LOGN);
  localparam int L  = int'(wb_lat(BF_LAT));
  localparam int WW = $clog2(L + 1);

  localparam logic [LOGN-2:0] JLast     = '1;
  localparam logic [SW-1:0]   StageTop  = SW'(LOGN - 1);
  localparam logic [WW-1:0]   WaitLast  = WW'(L - 1);

  ntt_state_e      state_q;
  logic [LOGN-2:0] j_q;
  logic [SW-1:0]   stage_q;
  logic [WW-1:0]   wcnt_q;
  logic            mode_q;
  logic            busy_q;
  logic            done_q;

  logic            hold;
  logic            last_stage;
  logic [SW-1:0]   stage_nxt;
  logic [LOGN-1:0] gen_a;
  logic [LOGN-1:0] gen_b;
  logic [LOGN-2:0] gen_tw;

  logic [L-1:0]    dl_en;
  logic [LOGN-1:0] dl_a [L];
  logic [LOGN-1:0] dl_b [L];

`ifdef NTT_CTRL_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // NTT walks stages upward, INTT downward.
  assign last_stage = mode_q ? (stage_q == '0) : (stage_q == StageTop);
  assign stage_nxt  = mode_q ? (stage_q - 1'b1) : (stage_q + 1'b1);

  ntt_addr_gen #(
    .LOGN (LOGN),
    .SW   (SW)
  ) u_addr_gen (
    .j      (j_q),
    .s      (stage_q),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw     (gen_tw)
  );

  // Sequencing FSM: butterfly index, stage, drain counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      j_q     <= '0;
      stage_q <= '0;
      wcnt_q  <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            mode_q  <= inverse;
            busy_q  <= 1'b1;
            j_q     <= '0;
            wcnt_q  <= '0;
            stage_q <= inverse ? StageTop : '0;
          end
        end
        StRun: begin
          if (!hold) begin
            j_q <= j_q + 1'b1;
            if (j_q == JLast) begin
              state_q <= StWait;
              wcnt_q  <= '0;
            end
          end
        end
        StWait: begin
          if (!hold) begin
            if (wcnt_q == WaitLast) begin
              if (last_stage) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StRun;
                stage_q <= stage_nxt;
              end
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Addresses are forced to zero when idle so reset/idle outputs are clean.
  assign rd_en     = (state_q == StRun) && !hold;
  assign rd_addr_a = rd_en ? gen_a : '0;
  assign rd_addr_b = rd_en ? gen_b : '0;
  assign tw_addr   = rd_en ? gen_tw : '0;

  // Write-back delay line: read strobe/addresses shifted L cycles, never stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_en <= '0;
      for (int i = 0; i < L; i++) begin
        dl_a[i] <= '0;
        dl_b[i] <= '0;
      end
    end else begin
      dl_en[0] <= rd_en;
      dl_a[0]  <= rd_addr_a;
      dl_b[0]  <= rd_addr_b;
      for (int i = 1; i < L; i++) begin
        dl_en[i] <= dl_en[i-1];
        dl_a[i]  <= dl_a[i-1];
        dl_b[i]  <= dl_b[i-1];
      end
    end
  end

  assign wr_en     = dl_en[L-1];
  assign wr_addr_a = dl_a[L-1];
  assign wr_addr_b = dl_b[L-1];

  assign busy  = busy_q;
  assign done  = done_q;
  assign mode  = mode_q;
  assign stage = stage_q;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl (LOGN=3, BF_LAT=2): expected read/write
// transactions with their cycle numbers are queued at start and popped as the
// DUT produces strobes. Stall scenario runs when NTT_CTRL_STALL_EN is defined.
module tb_ntt_ctrl;

  localparam int LOGN   = 3;
  localparam int BF_LAT = 2;
  localparam int N      = 8;
  localparam int HALF   = 4;
  localparam int L      = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       inverse = 1'b0;
`ifdef NTT_CTRL_STALL_EN
  logic       stall = 1'b0;
`endif
  logic       busy, done, mode, rd_en, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  logic [1:0] stage;

  ntt_ctrl #(
    .LOGN   (LOGN),
    .BF_LAT (BF_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .inverse   (inverse),
`ifdef NTT_CTRL_STALL_EN
    .stall     (stall),
`endif
    .busy      (busy),
    .done      (done),
    .mode      (mode),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_lo  = 1;
  int busy_hi  = 0;
  int done_at  = -1;

  typedef struct {int cyc; int a; int b; int tw; int s; int md;} rd_exp_t;
  typedef struct {int cyc; int a; int b;} wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference address sequence built block-wise, independent of the j/m formula.
  task automatic push_xform(input int c, input bit inv, input int st_at, input int st_len);
    int idx, s, m, tc;
    rd_exp_t re;
    wr_exp_t we;
    for (int si = 0; si < LOGN; si++) begin
      s   = inv ? (LOGN - 1 - si) : si;
      m   = 1 << s;
      idx = 0;
      for (int blk = 0; blk < N; blk += 2 * m) begin
        for (int k = 0; k < m; k++) begin
          tc = c + 1 + si * (HALF + L) + idx;
          if (st_len > 0 && tc >= st_at) tc += st_len;
          re = '{tc, blk + k, blk + k + m, k * (HALF / m), s, int'(inv)};
          we = '{tc + L, blk + k, blk + k + m};
          rd_q.push_back(re);
          wr_q.push_back(we);
          idx++;
        end
      end
    end
    done_at = c + 1 + LOGN * (HALF + L) + st_len;
    busy_lo = c + 1;
    busy_hi = done_at;
  endtask

  // Called just after a rising edge; start is sampled at the next edge c.
  task automatic do_start(input bit inv, input int st_off, input int st_len, output int c);
    start   = 1'b1;
    inverse = inv;
    c       = cyc + 1;
    push_xform(c, inv, c + st_off, st_len);
    tick();
    start   = 1'b0;
    inverse = 1'b0;
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 2000 && (cyc + 1) < target; i++) tick();
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0 || (cyc + 1) <= done_at + 1) && i < 300) begin
      tick();
      i++;
    end
    check_eq({tag, "_rd_left"}, rd_q.size(), 0);
    check_eq({tag, "_wr_left"}, wr_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_mode"}, mode, 0);
    check_eq({tag, "_rd_en"}, rd_en, 0);
    check_eq({tag, "_wr_en"}, wr_en, 0);
    check_eq({tag, "_stage"}, stage, 0);
    check_eq({tag, "_rd_a"}, rd_addr_a, 0);
    check_eq({tag, "_rd_b"}, rd_addr_b, 0);
    check_eq({tag, "_tw"}, tw_addr, 0);
    check_eq({tag, "_wr_a"}, wr_addr_a, 0);
    check_eq({tag, "_wr_b"}, wr_addr_b, 0);
  endtask

  // Observe on the falling edge; t is the rising edge that samples this cycle.
  always @(negedge clk) begin : mon
    int t;
    rd_exp_t re;
    wr_exp_t we;
    t = cyc + 1;
    check_eq("busy", busy, (t >= busy_lo && t <= busy_hi));
    check_eq("done", done, (t == done_at));
    if (rd_en) begin
      if (rd_q.size() == 0) begin
        check_eq("rd_unexpected", rd_en, 0);
      end else begin
        re = rd_q.pop_front();
        check_eq("rd_cycle", t, re.cyc);
        check_eq("rd_addr_a", rd_addr_a, re.a);
        check_eq("rd_addr_b", rd_addr_b, re.b);
        check_eq("tw_addr", tw_addr, re.tw);
        check_eq("stage", stage, re.s);
        check_eq("mode", mode, re.md);
      end
    end
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        check_eq("wr_unexpected", wr_en, 0);
      end else begin
        we = wr_q.pop_front();
        check_eq("wr_cycle", t, we.cyc);
        check_eq("wr_addr_a", wr_addr_a, we.a);
        check_eq("wr_addr_b", wr_addr_b, we.b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) tick();
    @(negedge clk);
    check_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Forward transform; a start with inverse=1 mid-RUN must be ignored.
    do_start(1'b0, 0, 0, c);
    wait_until(c + 3);
    start   = 1'b1;
    inverse = 1'b1;
    tick();
    start   = 1'b0;
    inverse = 1'b0;
    drain("ntt");

    // Inverse transform; start held from the DONE cycle into the next IDLE cycle.
    do_start(1'b1, 0, 0, c);
    wait_until(c + 22);
    start = 1'b1;
    tick();
    push_xform(c + 23, 1'b0, 0, 0);
    tick();
    start = 1'b0;
    drain("b2b");

    // Reset while stage 1, j=2 is being read.
    do_start(1'b0, 0, 0, c);
    wait_until(c + 10);
    rst_n = 1'b0;
    rd_q.delete();
    wr_q.delete();
    done_at = -1;
    busy_lo = 1;
    busy_hi = 0;
    @(negedge clk);
    check_zero("mid_rst");
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    do_start(1'b1, 0, 0, c);
    drain("post_rst");

`ifdef NTT_CTRL_STALL_EN
    // Five stall cycles starting at stage 1, j=2.
    do_start(1'b0, 10, 5, c);
    wait_until(c + 10);
    stall = 1'b1;
    repeat (5) tick();
    stall = 1'b0;
    drain("stall");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
